// File: rtl/mem_stage_pkg.sv
// Shared pipeline header for the memory stage: bus widths, bubble constants,
// load/store opcodes, state encoding and byte-lane helpers.
package mem_stage_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [AluOpBus-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_misaligned(input logic [AluOpBus-1:0] op, input logic [1:0] a);
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return a[0];
    if (op inside {EXE_LW_OP, EXE_SW_OP})             return a != 2'b00;
    return 1'b0;
  endfunction

  // Big-endian lanes: sel[3] covers bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [AluOpBus-1:0] op, input logic [1:0] a);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b1000 >> a;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             return 4'b1111;
      default:                          return 4'b0000;
    endcase
  endfunction

  function automatic logic [RegBus-1:0] lane_wdata(input logic [AluOpBus-1:0] op,
                                                   input logic [RegBus-1:0] sdata);
    case (op)
      EXE_SB_OP: return {4{sdata[7:0]}};
      EXE_SH_OP: return {2{sdata[15:0]}};
      default:   return sdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus req/ack interface between the memory stage (master) and data memory (slave).
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_ldext.sv
// Load extractor: picks the addressed byte/halfword from the captured read word
// and sign- or zero-extends it for write-back.
module mem_ldext
  import mem_stage_pkg::*;
(
  input  logic [RegBus-1:0]   rdata,
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr,
  output logic [RegBus-1:0]   ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr[1] ? rdata[15:0] : rdata[31:16];

    case (aluop)
      EXE_LB_OP:  ext = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: ext = {24'b0, byte_lane};
      EXE_LH_OP:  ext = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: ext = {16'b0, half_lane};
      EXE_LW_OP:  ext = rdata;
      default:    ext = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores go through a req/ack bus while the
// pipeline is stalled. Optional macro MEM_ALIGN_CHECK_EN drops misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [RegBus-1:0]     mem_wdata_i,
  input  logic [AluOpBus-1:0]   mem_aluop_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     mem_sdata_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stall_req_o,
  mem_stage_if.master           bus,
  output logic                  align_err_o
);

  state_e            state;
  logic [RegBus-1:0] rdata_q;
  logic [RegBus-1:0] ld_value;
  logic              is_mem;
  logic              misalign;

  assign is_mem = is_load(mem_aluop_i) | is_store(mem_aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & is_misaligned(mem_aluop_i, mem_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign align_err_o = !rst && (state == ST_IDLE) && misalign;

  mem_ldext u_ldext (
    .rdata (rdata_q),
    .aluop (mem_aluop_i),
    .addr  (mem_addr_i[1:0]),
    .ext   (ld_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.sel   <= '0;
      bus.wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !misalign) begin
            bus.req   <= 1'b1;
            bus.we    <= is_store(mem_aluop_i);
            bus.addr  <= {mem_addr_i[31:2], 2'b00};
            bus.sel   <= lane_sel(mem_aluop_i, mem_addr_i[1:0]);
            bus.wdata <= lane_wdata(mem_aluop_i, mem_sdata_i);
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.ack) begin
            bus.req <= 1'b0;
            rdata_q <= bus.rdata;
            state   <= ST_DONE;
          end
        end
        // EX/MEM advances on this edge, so the same op is never reissued.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o        = mem_wd_i;
    wreg_o      = mem_wreg_i;
    wdata_o     = mem_wdata_i;
    stall_req_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem) begin
          wd_o        = NOPRegAddr;
          wreg_o      = 1'b0;
          wdata_o     = ZeroWord;
          stall_req_o = !misalign;
        end
      end
      ST_BUS: begin
        wd_o        = NOPRegAddr;
        wreg_o      = 1'b0;
        wdata_o     = ZeroWord;
        stall_req_o = 1'b1;
      end
      ST_DONE: begin
        if (is_load(mem_aluop_i)) wdata_o = ld_value;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Non-memory instructions pass straight through to write-back. Loads and stores run through a req/ack data-bus handshake, and the stage holds the pipeline with a stall request until the access completes.

## Interface
Parameters: none. Widths come from the shared header: RegAddrBus 5 bits, RegBus 32 bits, AluOpBus 8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd_i  in  5  destination register from EX/MEM
- mem_wreg_i  in  1  write-enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_aluop_i  in  8  operation code; load/store codes are defined in the shared header
- mem_addr_i  in  32  effective address
- mem_sdata_i  in  32  store data (rt)
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write-enable to MEM/WB
- wdata_o  out  32  write-back data to MEM/WB
- stall_req_o  out  1  hold EX/MEM and all earlier stages
- bus_req_o  out  1  data-bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address; bits [1:0] are forced to 00
- bus_sel_o  out  4  byte enables, big-endian: sel[3] selects bits [31:24]
- bus_wdata_o  out  32  store data, replicated across lanes
- bus_rdata_i  in  32  read data
- bus_ack_i  in  1  access complete, valid for one cycle
- align_err_o  out  1  misaligned-access pulse (see Configuration)

## Operation
The stage has three states: IDLE, BUS and DONE.

IDLE:
- Non-memory op: outputs are combinational copies of the inputs (wd_o=mem_wd_i, wreg_o=mem_wreg_i, wdata_o=mem_wdata_i). stall_req_o=0. Stay in IDLE.
- Memory op: stall_req_o=1. Present a bubble (wd_o=NOPRegAddr, wreg_o=0, wdata_o=0). Register the bus fields and go to BUS.

BUS:
- bus_req_o=1 and stall_req_o=1; output a bubble.
- Bus fields stay stable until ack.
- On bus_ack_i: capture bus_rdata_i into rdata_q and go to DONE.
- No ack: stay in BUS indefinitely.

DONE:
- stall_req_o=0 and bus_req_o=0.
- Loads: wdata_o = extended rdata_q.
- Stores: wdata_o = mem_wdata_i.
- wd_o=mem_wd_i and wreg_o=mem_wreg_i.
- Go to IDLE unconditionally. EX/MEM advances at this edge, so the next instruction is never mistaken for a repeat.

Byte lanes (a = addr[1:0]):
- LB/LBU/SB: sel = 4'b1000 >> a. Load byte taken from lane a; LB sign-extends, LBU zero-extends.
- LH/LHU/SH: sel = 4'b1100 when a[1]=0, else 4'b0011. LH sign-extends, LHU zero-extends.
- LW/SW: sel = 4'b1111.
- Store data: SB = {4{sdata[7:0]}}, SH = {2{sdata[15:0]}}, SW = sdata.
- bus_we_o=1 for stores, 0 for loads.

## Timing
- Reset: state=IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0, rdata_q=0, align_err_o=0. wd_o, wreg_o and wdata_o follow IDLE rules.
- Non-memory op: 0 added latency.
- Memory op with ack in the first BUS cycle: IDLE, BUS, DONE, i.e. 3 cycles and 2 stall cycles. Each wait cycle adds one BUS cycle.
- bus_ack_i outside BUS is ignored.
- rst during BUS: bus_req_o falls at that edge, the access is abandoned, and no write-back is produced.
- rdata is sampled only in the ack cycle.

## Configuration
Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword op with addr[0]=1, or word op with addr[1:0]≠00, is not issued to the bus.
  - No stall; the stage stays in IDLE.
  - The stage outputs a bubble (wreg_o=0) and align_err_o=1 combinationally for that cycle.
- Undefined:
  - align_err_o is tied to 0.
  - Halfwords ignore addr[0]; words ignore addr[1:0].
  - The access always proceeds.

## Structure
- Shared header holds:
  - RegAddrBus, RegBus and AluOpBus widths.
  - NOPRegAddr and ZeroWord.
  - EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP and EXE_SW_OP.
  - The state encodings.
- Sub-module mem_ldext (combinational): takes rdata_q, aluop and addr[1:0], returns the 32-bit extended load value.

## Test plan
- ADD result 0x0000_1234 to r5, non-memory -> same cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o=0.
- LB addr 0x101 with rdata 0x11_80_33_44, immediate ack -> sel=0100; 2 stall cycles; DONE wdata_o=0xFFFF_FF80.
- LHU addr 0x102 with rdata 0x1234_ABCD, ack after 3 wait cycles -> stall_req_o high for 5 cycles; wdata_o=0x0000_ABCD.
- SB addr 0x203 with sdata 0xDEAD_BE5A -> bus_we_o=1, sel=0001, bus_wdata_o=0x5A5A_5A5A, bus_addr_o=0x200.
- rst asserted during BUS with no ack -> next cycle bus_req_o=0, state IDLE, no write-back.
- LW addr 0x102 with MEM_ALIGN_CHECK_EN defined -> align_err_o=1, wreg_o=0, bus_req_o never asserted. With the macro undefined -> access proceeds at 0x100.
